// File: rtl/packet_route_ctrl_if.sv
// Handshake bundle between the input flit buffer, the switch allocator and
// the per-port route controller. The controller connects through 'master'.
interface packet_route_ctrl_if #(
   parameter int FLIT_SIZE = 16
) ();
   logic [FLIT_SIZE-1:0] flit_i;
   logic                 empty_i;
   logic                 read_o;
   logic                 grant_i;
   logic                 credit_i;
   logic                 req_o;
   logic [2:0]           out_port_o;
   logic [FLIT_SIZE-1:0] flit_o;
   logic                 flit_valid_o;
   logic                 err_o;

   modport master (
      input  flit_i, empty_i, grant_i, credit_i,
      output read_o, req_o, out_port_o, flit_o, flit_valid_o, err_o
   );

   modport slave (
      output flit_i, empty_i, grant_i, credit_i,
      input  read_o, req_o, out_port_o, flit_o, flit_valid_o, err_o
   );
endinterface

// File: rtl/packet_route_ctrl.sv
// Input-port packet controller: decodes head flits, XY-routes them, holds the
// switch request for the packet and forwards flits under grant and credits.
module packet_route_ctrl #(
   parameter int FLIT_SIZE   = 16,
   parameter int COORD_W     = 2,
   parameter int CUR_X       = 0,
   parameter int CUR_Y       = 0,
   parameter int BUFFER_SIZE = 8
) (
   input  logic                clk,
   input  logic                rst,
   packet_route_ctrl_if.master bus
);

   localparam int CW = $clog2(BUFFER_SIZE + 1);
   localparam logic [CW-1:0]      CRED_MAX = CW'(BUFFER_SIZE);
   localparam logic [COORD_W-1:0] CX       = COORD_W'(CUR_X);
   localparam logic [COORD_W-1:0] CY       = COORD_W'(CUR_Y);

   localparam logic [2:0] P_LOCAL = 3'd0;
   localparam logic [2:0] P_NORTH = 3'd1;
   localparam logic [2:0] P_EAST  = 3'd2;
   localparam logic [2:0] P_SOUTH = 3'd3;
   localparam logic [2:0] P_WEST  = 3'd4;

   typedef enum logic [1:0] {IDLE, ROUTING, ACTIVE} state_t;

   state_t              state_q;
   logic                req_q;
   logic [2:0]          out_port_q;
   logic                err_q;
   logic [CW-1:0]       credit_cnt_q;
   logic [COORD_W-1:0]  dest_x_q, dest_y_q;

   logic [1:0]          ftype;
   logic                is_head, is_last;
   logic                xfer, drop, cred_ovf;

   // X dimension is resolved fully before Y, which keeps the mesh deadlock-free.
   function automatic logic [2:0] xy_route(input logic [COORD_W-1:0] dx,
                                           input logic [COORD_W-1:0] dy);
      if (dx > CX)      return P_EAST;
      else if (dx < CX) return P_WEST;
      else if (dy > CY) return P_NORTH;
      else if (dy < CY) return P_SOUTH;
      else              return P_LOCAL;
   endfunction

   assign ftype   = bus.flit_i[FLIT_SIZE-1:FLIT_SIZE-2];
   assign is_head = (ftype == 2'b00) || (ftype == 2'b11);
   assign is_last = ftype[1];

   assign xfer     = (state_q == ACTIVE) && bus.grant_i && !bus.empty_i
                     && (credit_cnt_q != '0);
   assign drop     = (state_q == IDLE) && !bus.empty_i && !is_head;
   assign cred_ovf = bus.credit_i && !xfer && (credit_cnt_q == CRED_MAX);

   // Pops are masked during reset so a stray flit is never consumed then.
   assign bus.read_o       = (xfer || drop) && !rst;
   assign bus.flit_valid_o = xfer && !rst;
   assign bus.flit_o       = bus.flit_i;
   assign bus.req_o        = req_q;
   assign bus.out_port_o   = out_port_q;
   assign bus.err_o        = err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         req_q        <= 1'b0;
         out_port_q   <= P_LOCAL;
         err_q        <= 1'b0;
         credit_cnt_q <= CRED_MAX;
         dest_x_q     <= '0;
         dest_y_q     <= '0;
      end else begin
         err_q <= drop || cred_ovf;

         if (xfer && !bus.credit_i)
            credit_cnt_q <= credit_cnt_q - 1'b1;
         else if (!xfer && bus.credit_i && (credit_cnt_q != CRED_MAX))
            credit_cnt_q <= credit_cnt_q + 1'b1;

         case (state_q)
            IDLE: begin
               if (!bus.empty_i && is_head) begin
                  dest_x_q <= bus.flit_i[2*COORD_W-1:COORD_W];
                  dest_y_q <= bus.flit_i[COORD_W-1:0];
                  state_q  <= ROUTING;
               end
            end
            ROUTING: begin
               out_port_q <= xy_route(dest_x_q, dest_y_q);
               req_q      <= 1'b1;
               state_q    <= ACTIVE;
            end
            ACTIVE: begin
               if (xfer && is_last) begin
                  req_q   <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_packet_route_ctrl.sv
// Directed bench for packet_route_ctrl at router (1,1) with an 8-deep downstream.
module tb_packet_route_ctrl;

   localparam int FS = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   packet_route_ctrl_if #(.FLIT_SIZE(FS)) bus ();

   packet_route_ctrl #(
      .FLIT_SIZE(FS), .COORD_W(2), .CUR_X(1), .CUR_Y(1), .BUFFER_SIZE(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_chk = 0;
   int n_err = 0;
   logic [FS-1:0] q[$];
   int xfers;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [FS-1:0] mk(input logic [1:0] t, input logic [9:0] pl,
                                        input logic [1:0] dx, input logic [1:0] dy);
      return {t, pl, dx, dy};
   endfunction

   task automatic upd();
      bus.empty_i = (q.size() == 0);
      bus.flit_i  = (q.size() == 0) ? '0 : q[0];
   endtask

   // One clock: sample combinational pop, advance, model the buffer, drop the credit pulse.
   task automatic cyc();
      logic rd;
      #1;
      rd = bus.read_o;
      if (bus.flit_valid_o) xfers++;
      @(posedge clk);
      #1;
      if (rd && q.size() > 0) void'(q.pop_front());
      bus.credit_i = 1'b0;
      upd();
      #1;
   endtask

   task automatic credits(input int n);
      for (int i = 0; i < n; i++) begin
         bus.credit_i = 1'b1;
         cyc();
      end
   endtask

   // Single-flit packet: route latency, transfer slot, request drop, credit use.
   task automatic send_single(input logic [1:0] dx, input logic [1:0] dy, input logic [2:0] port);
      logic [FS-1:0] f;
      f = mk(2'b11, 10'h155, dx, dy);
      q.push_back(f);
      upd();
      #1;
      chk("st_head_nopop", 32'(bus.read_o), 0);
      cyc();
      chk("st_routing_req", 32'(bus.req_o), 0);
      cyc();
      chk("st_req", 32'(bus.req_o), 1);
      chk("st_port", 32'(bus.out_port_o), 32'(port));
      chk("st_fv", 32'(bus.flit_valid_o), 1);
      chk("st_flit", 32'(bus.flit_o), 32'(f));
      cyc();
      chk("st_req_drop", 32'(bus.req_o), 0);
      chk("st_cnt7", 32'(dut.credit_cnt_q), 7);
      credits(1);
   endtask

   logic [1:0] t_dx [5] = '{2'd3, 2'd1, 2'd1, 2'd1, 2'd0};
   logic [1:0] t_dy [5] = '{2'd0, 2'd2, 2'd1, 2'd0, 2'd3};
   logic [2:0] t_pt [5] = '{3'd2, 3'd1, 3'd0, 3'd3, 3'd4};

   initial begin
      logic [FS-1:0] pk [10];
      bus.grant_i  = 1'b0;
      bus.credit_i = 1'b0;
      q.push_back(mk(2'b01, 10'h3, 2'd2, 2'd2));
      upd();
      repeat (3) @(posedge clk);
      #1;
      // Reset state, with a stray BODY at the head that must not be popped.
      chk("rst_req", 32'(bus.req_o), 0);
      chk("rst_port", 32'(bus.out_port_o), 0);
      chk("rst_err", 32'(bus.err_o), 0);
      chk("rst_read", 32'(bus.read_o), 0);
      chk("rst_fv", 32'(bus.flit_valid_o), 0);
      chk("rst_cnt", 32'(dut.credit_cnt_q), 8);
      q.delete();
      upd();
      rst = 1'b0;
      bus.grant_i = 1'b1;
      #1;

      for (int i = 0; i < 5; i++) send_single(t_dx[i], t_dy[i], t_pt[i]);

      // 4-flit packet north, back-to-back transfers.
      pk[0] = mk(2'b00, 10'h010, 2'd1, 2'd2);
      pk[1] = mk(2'b01, 10'h011, 2'd0, 2'd0);
      pk[2] = mk(2'b01, 10'h012, 2'd0, 2'd0);
      pk[3] = mk(2'b10, 10'h013, 2'd0, 2'd0);
      for (int i = 0; i < 4; i++) q.push_back(pk[i]);
      upd();
      cyc(); cyc();
      chk("p4_req", 32'(bus.req_o), 1);
      chk("p4_port", 32'(bus.out_port_o), 1);
      for (int i = 0; i < 4; i++) begin
         chk("p4_fv", 32'(bus.flit_valid_o), 1);
         chk("p4_flit", 32'(bus.flit_o), 32'(pk[i]));
         cyc();
      end
      chk("p4_req_end", 32'(bus.req_o), 0);
      chk("p4_cnt", 32'(dut.credit_cnt_q), 4);
      credits(4);
      chk("p4_cnt_back", 32'(dut.credit_cnt_q), 8);

      // Credit exhaustion: 10-flit packet with 8 credits stalls after 8 transfers.
      pk[0] = mk(2'b00, 10'h020, 2'd2, 2'd1);
      for (int i = 1; i < 9; i++) pk[i] = mk(2'b01, 10'(32 + i), 2'd0, 2'd0);
      pk[9] = mk(2'b10, 10'h02f, 2'd0, 2'd0);
      for (int i = 0; i < 10; i++) q.push_back(pk[i]);
      upd();
      cyc(); cyc();
      xfers = 0;
      repeat (12) cyc();
      chk("cr_xfers", 32'(xfers), 8);
      chk("cr_req_stall", 32'(bus.req_o), 1);
      chk("cr_cnt0", 32'(dut.credit_cnt_q), 0);
      chk("cr_read_stall", 32'(bus.read_o), 0);
      xfers = 0;
      bus.credit_i = 1'b1;
      cyc();
      cyc();
      cyc();
      chk("cr_one_more", 32'(xfers), 1);
      chk("cr_req_held", 32'(bus.req_o), 1);
      bus.credit_i = 1'b1;
      cyc();
      chk("cr_cnt1", 32'(dut.credit_cnt_q), 1);
      // Tail transfer coincides with a credit return.
      bus.credit_i = 1'b1;
      #1;
      chk("cr_tail_fv", 32'(bus.flit_valid_o), 1);
      chk("cr_tail_flit", 32'(bus.flit_o), 32'(pk[9]));
      cyc();
      chk("cr_same_cyc", 32'(dut.credit_cnt_q), 1);
      chk("cr_req_end", 32'(bus.req_o), 0);
      credits(7);
      chk("cr_cnt8", 32'(dut.credit_cnt_q), 8);
      credits(1);
      chk("ovf_err", 32'(bus.err_o), 1);
      chk("ovf_cnt", 32'(dut.credit_cnt_q), 8);
      cyc();
      chk("ovf_err_clr", 32'(bus.err_o), 0);

      // Stray BODY in IDLE is dropped, then the next head is routed.
      q.push_back(mk(2'b01, 10'h0aa, 2'd3, 2'd3));
      pk[0] = mk(2'b11, 10'h0bb, 2'd1, 2'd2);
      q.push_back(pk[0]);
      upd();
      #1;
      chk("st_drop_read", 32'(bus.read_o), 1);
      chk("st_drop_fv", 32'(bus.flit_valid_o), 0);
      cyc();
      chk("st_drop_err", 32'(bus.err_o), 1);
      chk("st_drop_noreq", 32'(bus.req_o), 0);
      chk("st_head_nopop2", 32'(bus.read_o), 0);
      cyc();
      chk("st_err_clr", 32'(bus.err_o), 0);
      cyc();
      chk("st_next_req", 32'(bus.req_o), 1);
      chk("st_next_port", 32'(bus.out_port_o), 1);
      chk("st_next_flit", 32'(bus.flit_o), 32'(pk[0]));
      cyc();
      credits(1);

      // Reset mid-packet after 2 of 4 flits.
      q.push_back(mk(2'b00, 10'h040, 2'd3, 2'd3));
      q.push_back(mk(2'b01, 10'h041, 2'd0, 2'd0));
      q.push_back(mk(2'b01, 10'h042, 2'd0, 2'd0));
      q.push_back(mk(2'b10, 10'h043, 2'd0, 2'd0));
      upd();
      cyc(); cyc();
      chk("mr_port", 32'(bus.out_port_o), 2);
      cyc(); cyc();
      chk("mr_cnt6", 32'(dut.credit_cnt_q), 6);
      rst = 1'b1;
      #1;
      chk("mr_req", 32'(bus.req_o), 0);
      chk("mr_port0", 32'(bus.out_port_o), 0);
      chk("mr_cnt8", 32'(dut.credit_cnt_q), 8);
      chk("mr_read", 32'(bus.read_o), 0);
      q.delete();
      upd();
      cyc();
      rst = 1'b0;
      pk[0] = mk(2'b11, 10'h050, 2'd0, 2'd0);
      q.push_back(pk[0]);
      upd();
      cyc();
      chk("mr_lat1", 32'(bus.req_o), 0);
      cyc();
      chk("mr_req2", 32'(bus.req_o), 1);
      chk("mr_port_w", 32'(bus.out_port_o), 4);
      chk("mr_fv", 32'(bus.flit_valid_o), 1);
      cyc();
      chk("mr_done", 32'(bus.req_o), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
